// File: rtl/sram_responder.sv
// Unified 32-bit word memory serving the core's inst/data SRAM buses; zero-fills after reset (SRAM_RESP_PRELOAD_EN: no fill).
// Latency: 1-cycle read on both buses; byte-enable writes on the data bus only; out-of-window accesses set a sticky oob_err.
// Backpressure: none, both buses are accepted every RUN cycle; core_resetn holds the core off until the fill is done.
module sram_responder #(
    parameter int          ADDR_W    = 14,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter              INIT_FILE = "inst.hex"
) (
    input  logic        clk,
    input  logic        resetn,
    output logic        core_resetn,
    input  logic        inst_sram_en,
    input  logic [3:0]  inst_sram_wen,
    input  logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_wdata,
    output logic [31:0] inst_sram_rdata,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic        oob_err
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_t;

`ifdef SRAM_RESP_PRELOAD_EN
    localparam state_t RST_STATE = RUN;
`else
    localparam state_t RST_STATE = INIT;
`endif

    logic [31:0]       mem [DEPTH];
    state_t            state_q;
    logic [ADDR_W-1:0] cnt_q;
    logic              core_resetn_q;
    logic [31:0]       inst_rdata_q;
    logic [31:0]       data_rdata_q;
    logic              oob_q;

    logic [ADDR_W-1:0] inst_idx;
    logic [ADDR_W-1:0] data_idx;
    logic              inst_hit;
    logic              data_hit;
    logic              data_rd;
    logic              data_wr;
    logic              fill_we;

    assign inst_idx = inst_sram_addr[ADDR_W+1:2];
    assign data_idx = data_sram_addr[ADDR_W+1:2];
    assign inst_hit = (inst_sram_addr[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]);
    assign data_hit = (data_sram_addr[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]);
    assign data_rd  = (state_q == RUN) && data_sram_en && (data_sram_wen == 4'd0);
    assign data_wr  = (state_q == RUN) && data_sram_en && (data_sram_wen != 4'd0) && data_hit;
    assign fill_we  = (state_q == INIT);

    // The instruction bus is read-only: its write lanes and the unused address/init bits are folded away here.
    logic unused_bits;
    assign unused_bits = ^{inst_sram_wen, inst_sram_wdata, inst_sram_addr[1:0], data_sram_addr[1:0]};
    localparam int unused_init_w = $bits(INIT_FILE);

    always_ff @(posedge clk) begin
        if (fill_we) begin
            mem[cnt_q] <= 32'h0;
        end else if (data_wr) begin
            for (int k = 0; k < 4; k++) begin
                if (data_sram_wen[k]) begin
                    mem[data_idx][8*k +: 8] <= data_sram_wdata[8*k +: 8];
                end
            end
        end
    end

    // Reads sample mem before this edge's write lands, giving read-before-write on a same-cycle collision.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= RST_STATE;
            cnt_q         <= '0;
            core_resetn_q <= 1'b0;
            inst_rdata_q  <= 32'h0;
            data_rdata_q  <= 32'h0;
            oob_q         <= 1'b0;
        end else begin
            case (state_q)
                INIT: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == {ADDR_W{1'b1}}) begin
                        state_q       <= RUN;
                        core_resetn_q <= 1'b1;
                    end
                end
                RUN: begin
                    core_resetn_q <= 1'b1;
                    if (inst_sram_en) begin
                        inst_rdata_q <= inst_hit ? mem[inst_idx] : 32'h0;
                    end
                    if (data_rd) begin
                        data_rdata_q <= data_hit ? mem[data_idx] : 32'h0;
                    end
                    if ((inst_sram_en && !inst_hit) || (data_sram_en && !data_hit)) begin
                        oob_q <= 1'b1;
                    end
                end
                default: state_q <= RST_STATE;
            endcase
        end
    end

    assign core_resetn     = core_resetn_q;
    assign inst_sram_rdata = inst_rdata_q;
    assign data_sram_rdata = data_rdata_q;
    assign oob_err         = oob_q;
endmodule

// File: tb/tb_sram_responder.sv
// Directed bench for sram_responder (ADDR_W=4): scoreboard queues of expected rdata, immediate-assertion checks.
module tb_sram_responder;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        core_resetn;
    logic        inst_sram_en = 1'b0;
    logic [3:0]  inst_sram_wen = 4'h0;
    logic [31:0] inst_sram_addr = 32'h0;
    logic [31:0] inst_sram_wdata = 32'h0;
    logic [31:0] inst_sram_rdata;
    logic        data_sram_en = 1'b0;
    logic [3:0]  data_sram_wen = 4'h0;
    logic [31:0] data_sram_addr = 32'h0;
    logic [31:0] data_sram_wdata = 32'h0;
    logic [31:0] data_sram_rdata;
    logic        oob_err;

    sram_responder #(.ADDR_W(AW), .BASE_ADDR(32'h0), .INIT_FILE("inst.hex")) dut (
        .clk(clk), .resetn(resetn), .core_resetn(core_resetn),
        .inst_sram_en(inst_sram_en), .inst_sram_wen(inst_sram_wen),
        .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
        .inst_sram_rdata(inst_sram_rdata),
        .data_sram_en(data_sram_en), .data_sram_wen(data_sram_wen),
        .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
        .data_sram_rdata(data_sram_rdata), .oob_err(oob_err)
    );

    always #5 clk = ~clk;

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] model [DEPTH];
    logic [31:0] prev_i = 32'h0;
    logic [31:0] prev_d = 32'h0;
    logic        oob_exp = 1'b0;
    logic [31:0] q_i [$];
    logic [31:0] q_d [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
        prev_i  = 32'h0;
        prev_d  = 32'h0;
        oob_exp = 1'b0;
        q_i.delete();
        q_d.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_core_resetn"}, {31'h0, core_resetn}, 32'h0);
        check({tag, "_inst_rdata"}, inst_sram_rdata, 32'h0);
        check({tag, "_data_rdata"}, data_sram_rdata, 32'h0);
        check({tag, "_oob"}, {31'h0, oob_err}, 32'h0);
    endtask

    // Counts cycles from reset release until core_resetn rises, bounded.
    task automatic wait_init(input string tag);
        int n = 0;
        while (!core_resetn && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(tag, n, 16);
    endtask

    task automatic step(input string tag,
                        input logic ie, input logic [31:0] ia, input logic [3:0] iw, input logic [31:0] iwd,
                        input logic de, input logic [3:0] dw, input logic [31:0] da, input logic [31:0] dd);
        @(negedge clk);
        inst_sram_en = ie; inst_sram_addr = ia; inst_sram_wen = iw; inst_sram_wdata = iwd;
        data_sram_en = de; data_sram_addr = da; data_sram_wen = dw; data_sram_wdata = dd;
        if (ie) prev_i = (ia[31:6] == 26'h0) ? model[ia[5:2]] : 32'h0;
        if (de && dw == 4'h0) prev_d = (da[31:6] == 26'h0) ? model[da[5:2]] : 32'h0;
        if ((ie && ia[31:6] != 26'h0) || (de && da[31:6] != 26'h0)) oob_exp = 1'b1;
        q_i.push_back(prev_i);
        q_d.push_back(prev_d);
        if (de && dw != 4'h0 && da[31:6] == 26'h0) begin
            for (int k = 0; k < 4; k++)
                if (dw[k]) model[da[5:2]][8*k +: 8] = dd[8*k +: 8];
        end
        @(posedge clk);
        #1;
        inst_sram_en = 1'b0; inst_sram_wen = 4'h0; inst_sram_wdata = 32'h0;
        data_sram_en = 1'b0; data_sram_wen = 4'h0;
        check({tag, "_inst"}, inst_sram_rdata, q_i.pop_front());
        check({tag, "_data"}, data_sram_rdata, q_d.pop_front());
        check({tag, "_oob"}, {31'h0, oob_err}, {31'h0, oob_exp});
    endtask

    initial begin
        clear_model();
        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        resetn = 1'b1;
        wait_init("init_len");

        for (int i = 0; i < DEPTH; i++)
            step("rd_all", 1'b1, 32'(i * 4), 4'h0, 32'h0, 1'b1, 4'h0, 32'(i * 4), 32'h0);

        step("wr_full", 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 4'hF, 32'h8, 32'hDEAD_BEEF);
        step("rd_full", 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 4'h0, 32'h8, 32'h0);
        check("rd_full_value", data_sram_rdata, 32'hDEAD_BEEF);
        step("wr_part", 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 4'b0101, 32'h8, 32'h1122_3344);
        step("rd_part", 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 4'h0, 32'h8, 32'h0);
        check("rd_part_value", data_sram_rdata, 32'hDE22_BE44);

        step("rbw", 1'b1, 32'h10, 4'h0, 32'h0, 1'b1, 4'hF, 32'h10, 32'hCAFE_F00D);
        check("rbw_old", inst_sram_rdata, 32'h0);
        step("b2b", 1'b1, 32'h10, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
        check("b2b_new", inst_sram_rdata, 32'hCAFE_F00D);

        step("inst_wen", 1'b1, 32'h8, 4'hF, 32'hFFFF_FFFF, 1'b0, 4'h0, 32'h0, 32'h0);
        step("inst_wen_rd", 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 4'h0, 32'h8, 32'h0);

        step("oob_rd", 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 4'h0, 32'h40, 32'h0);
        check("oob_rd_zero", data_sram_rdata, 32'h0);
        step("oob_hold", 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
        step("oob_wr", 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 4'hF, 32'h40, 32'h1234_5678);
        for (int i = 0; i < DEPTH; i++)
            step("oob_scan", 1'b1, 32'(i * 4), 4'h0, 32'h0, 1'b1, 4'h0, 32'(i * 4), 32'h0);

        step("pre_rst", 1'b1, 32'h10, 4'h0, 32'h0, 1'b1, 4'h0, 32'h8, 32'h0);
        #2;
        resetn = 1'b0;
        #1;
        check_reset_outputs("run_rst");
        clear_model();

        @(negedge clk);
        resetn = 1'b1;
        repeat (5) @(posedge clk);
        #2;
        resetn = 1'b0;
        #1;
        check_reset_outputs("mid_init_rst");
        @(negedge clk);
        resetn = 1'b1;
        wait_init("reinit_len");
        step("post_reinit", 1'b1, 32'h10, 4'h0, 32'h0, 1'b1, 4'h0, 32'h8, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
